seq_signed_divider: RTL and testbench

//  Iterative signed N-bit divider: quotient and remainder of dividend/divisor, one quotient bit per clock.

---
 rtl/divider_pkg.sv | 23 ++
 rtl/div_iter_step.sv | 31 +++
 rtl/seq_signed_divider.sv | 127 ++++++++++++
 tb/tb_seq_signed_divider.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared definitions for the sequential signed divider.
// Contents:
//   DEFAULT_N      default operand width (dividend, divisor, quotient, remainder)
//   DEFAULT_CNT_W  iteration counter width for the default operand width
//   state_t        controller states
//   cntWidth()     iteration counter width for an arbitrary operand width
package divider_pkg;

  localparam int DEFAULT_N     = 32;
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_N);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

  // The counter must hold N-1, which is the last iteration index.
  function automatic int cntWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step (purely combinational).
// Ports:
//   i_rem      partial remainder before this step (N+1 bits, always < divisor magnitude)
//   i_bit      next dividend magnitude bit, MSB first
//   i_divisor  divisor magnitude (N+1 bits, so -2^(N-1) is represented exactly)
//   o_rem      partial remainder after this step
//   o_qBit     quotient bit produced by this step
module div_iter_step #(
  parameter int N = 32
) (
  input  logic [N:0] i_rem,
  input  logic       i_bit,
  input  logic [N:0] i_divisor,
  output logic [N:0] o_rem,
  output logic       o_qBit
);

  logic [N+1:0] w_part;
  logic [N:0]   w_diff;

  // The trial value is one bit wider than the remainder. The compare uses the
  // full width. The subtraction only needs N+1 bits: it is kept only when the
  // trial is at least the divisor, and then the result is below the divisor.
  always_comb begin
    w_part = {i_rem, i_bit};
    w_diff = w_part[N:0] - i_divisor;
    o_qBit = (w_part >= {1'b0, i_divisor});
    o_rem  = o_qBit ? w_diff : w_part[N:0];
  end

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed divider: produces one quotient bit per clock.
// It uses a start/busy/done handshake. Results are held until the next start.
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   start         request; accepted only while busy is low
//   dividend      signed operand, captured when start is accepted
//   divisor       signed operand, captured when start is accepted
//   busy          high from acceptance until the done cycle
//   done          one-cycle pulse; marks quotient/remainder/div_by_zero valid
//   quotient      signed, truncated toward zero
//   remainder     signed; its sign follows the dividend
//   div_by_zero   set with done when the divisor was zero
module seq_signed_divider
  import divider_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = cntWidth(N);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [N:0]    r_rem;
  logic [N-1:0]  r_q;
  logic [N:0]    r_absDivisor;
  logic          r_qNeg;
  logic          r_remNeg;
  logic          r_zero;

  logic [N:0]    w_absDividend;
  logic [N:0]    w_absDivisor;
  logic [N:0]    w_nextRem;
  logic          w_qBit;

  // Magnitudes are taken after sign extension to N+1 bits.
  // This makes the most negative operand become a proper positive value.
  always_comb begin
    w_absDividend = dividend[N-1] ? -{dividend[N-1], dividend} : {1'b0, dividend};
    w_absDivisor  = divisor[N-1]  ? -{divisor[N-1], divisor}   : {1'b0, divisor};
  end

  // r_q serves two purposes. Dividend bits leave at its top, one per step.
  // Quotient bits enter at its bottom.
  div_iter_step #(.N(N)) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_q[N-1]),
    .i_divisor (r_absDivisor),
    .o_rem     (w_nextRem),
    .o_qBit    (w_qBit)
  );

  // Controller with registered outputs.
  // For division by zero, the dividend magnitude is parked in r_rem.
  // The FIX state then re-applies the dividend sign, which restores the original dividend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_rem        <= '0;
      r_q          <= '0;
      r_absDivisor <= '0;
      r_qNeg       <= 1'b0;
      r_remNeg     <= 1'b0;
      r_zero       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      quotient     <= '0;
      remainder    <= '0;
      div_by_zero  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            busy         <= 1'b1;
            div_by_zero  <= 1'b0;
            r_absDivisor <= w_absDivisor;
            r_qNeg       <= dividend[N-1] ^ divisor[N-1];
            r_remNeg     <= dividend[N-1];
            if (divisor == '0) begin
              r_zero  <= 1'b1;
              r_rem   <= w_absDividend;
              r_q     <= '1;
              r_state <= FIX;
            end else begin
              r_zero  <= 1'b0;
              r_rem   <= '0;
              r_q     <= w_absDividend[N-1:0];
              r_cnt   <= CW'(N - 1);
              r_state <= CALC;
            end
          end
        end
        CALC: begin
          r_rem <= w_nextRem;
          r_q   <= {r_q[N-2:0], w_qBit};
          if (r_cnt == '0) begin
            r_state <= FIX;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        FIX: begin
          done        <= 1'b1;
          busy        <= 1'b0;
          div_by_zero <= r_zero;
          quotient    <= r_zero ? '1 : (r_qNeg ? -r_q : r_q);
          remainder   <= r_remNeg ? -r_rem[N-1:0] : r_rem[N-1:0];
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
module tb_seq_signed_divider;

  localparam int N      = 32;
  localparam int BUDGET = N + 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    int           lat;
  } exp_t;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
  } vec_t;

  exp_t         sbQueue[$];
  vec_t         vecs[11];
  int           nCompared   = 0;
  int           nMismatched = 0;
  logic [N-1:0] lastQ;
  bit           haveLast;

  // Free-running clock; the DUT is driven and sampled on falling edges.
  always #5 clk = ~clk;

  seq_signed_divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic checkVal(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d (0x%h) want %0d (0x%h)", name, $signed(act), act, $signed(exp), exp);
    end
  endtask

  // Drives one request and queues its expected result.
  // With backToBack set, the request is driven in the current (done) cycle.
  task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b,
                               input logic [N-1:0] q, input logic [N-1:0] r,
                               input logic dbz, input bit backToBack);
    exp_t e;
    if (!backToBack) @(negedge clk);
    e.q   = q;
    e.r   = r;
    e.dbz = dbz;
    e.lat = dbz ? 1 : N + 1;
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sbQueue.push_back(e);
  endtask

  // Waits (bounded) for done, then pops the scoreboard and compares.
  // Cycle j is observed on the falling edge after accept edge + j.
  task automatic checkOutput(input bit pulseWhileBusy);
    exp_t e;
    bit   seenDone;
    int   j;
    seenDone = 1'b0;
    for (j = 0; j < BUDGET; j++) begin
      @(negedge clk);
      if (j == 0) begin
        start = 1'b0;
        checkVal("busyAfterAccept", {31'b0, busy}, 32'd1);
      end
      if (j == 2 && haveLast && !done) checkVal("holdQuotient", quotient, lastQ);
      if (pulseWhileBusy && j == 4) begin
        start    = 1'b1;
        dividend = 32'd555;
        divisor  = 32'd3;
      end
      if (pulseWhileBusy && j == 5) start = 1'b0;
      if (done) begin
        seenDone = 1'b1;
        break;
      end
    end
    e = sbQueue.pop_front();
    if (!seenDone) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL doneTimeout: got no done within %0d cycles, want done", BUDGET);
    end else begin
      checkVal("quotient", quotient, e.q);
      checkVal("remainder", remainder, e.r);
      checkVal("divByZero", {31'b0, div_by_zero}, {31'b0, e.dbz});
      checkVal("busyInDone", {31'b0, busy}, 32'd0);
      checkVal("latency", N'(j), N'(e.lat));
      lastQ    = e.q;
      haveLast = 1'b1;
    end
  endtask

  initial begin
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    longint       la;
    longint       lb;
    int           doneCount;

    vecs[0]  = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0};
    vecs[1]  = '{-32'sd263875, 32'd125, -32'sd2111, 32'd0, 1'b0};
    vecs[2]  = '{-32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0};
    vecs[3]  = '{32'd100, -32'sd7, -32'sd14, 32'd2, 1'b0};
    vecs[4]  = '{32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF, 1'b0};
    vecs[5]  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0};
    vecs[6]  = '{32'd1822436743, 32'd0, 32'hFFFF_FFFF, 32'd1822436743, 1'b1};
    vecs[7]  = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0};
    vecs[8]  = '{32'd7, 32'd100, 32'd0, 32'd7, 1'b0};
    vecs[9]  = '{-32'sd1, 32'd1, -32'sd1, 32'd0, 1'b0};
    vecs[10] = '{-32'sd50, 32'd0, 32'hFFFF_FFFF, -32'sd50, 1'b1};

    haveLast = 1'b0;
    lastQ    = '0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    #12;
    checkVal("resetBusy", {31'b0, busy}, 32'd0);
    checkVal("resetDone", {31'b0, done}, 32'd0);
    checkVal("resetQuotient", quotient, 32'd0);
    checkVal("resetRemainder", remainder, 32'd0);
    checkVal("resetDbz", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz, 1'b0);
      checkOutput(1'b0);
    end

    // Randomised operands against a wide-integer model
    for (int i = 0; i < 12; i++) begin
      ra = N'($urandom);
      rb = (i < 6) ? N'($urandom_range(1, 1000)) : N'($urandom);
      if (i % 3 == 1) rb = -rb;
      if (rb == '0) rb = 32'd3;
      la = longint'($signed(ra));
      lb = longint'($signed(rb));
      applyStimulus(ra, rb, N'(la / lb), N'(la % lb), 1'b0, 1'b0);
      checkOutput(1'b0);
    end

    // Start pulsed while busy must be ignored; no further operation may follow
    applyStimulus(32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 1'b0);
    checkOutput(1'b1);
    @(negedge clk);
    checkVal("donePulseWidth", {31'b0, done}, 32'd0);
    checkVal("noGhostBusy", {31'b0, busy}, 32'd0);

    // Back-to-back: start driven during the done cycle
    applyStimulus(-32'sd100, 32'd7, -32'sd14, -32'sd2, 1'b0, 1'b0);
    checkOutput(1'b0);
    applyStimulus(32'd99, -32'sd10, -32'sd9, 32'd9, 1'b0, 1'b1);
    checkOutput(1'b0);

    // Reset mid-CALC aborts without a done
    applyStimulus(32'd123456, 32'd789, 32'd156, 32'd372, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    sbQueue.delete();
    checkVal("abortBusy", {31'b0, busy}, 32'd0);
    checkVal("abortQuotient", quotient, 32'd0);
    checkVal("abortRemainder", remainder, 32'd0);
    checkVal("abortDbz", {31'b0, div_by_zero}, 32'd0);
    lastQ = '0;
    @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkVal("noDoneAfterAbort", N'(doneCount), 32'd0);
    applyStimulus(32'd123456, 32'd789, 32'd156, 32'd372, 1'b0, 1'b0);
    checkOutput(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
